// File: rtl/approx_sweep_ctrl_if.sv
// approx_sweep_ctrl_if: host/DUT-pair side of the sweep controller bundled as one bus.
interface approx_sweep_ctrl_if #(
    parameter int N_IN = 5,
    parameter int N_OUT = 2,
    parameter int CNT_W = N_IN + 1
);
    logic                   IN_start;
    logic                   IN_abort;
    logic [N_OUT-1:0]       IN_exact;
    logic [N_OUT-1:0]       IN_approx;
    logic [N_IN-1:0]        OUT_vec;
    logic                   OUT_busy;
    logic                   OUT_done;
    logic                   OUT_aborted;
    logic [N_OUT*CNT_W-1:0] OUT_err_cnt;
    logic [CNT_W-1:0]       OUT_any_cnt;
    logic [N_IN-1:0]        OUT_first_fail;
    logic                   OUT_first_valid;

    modport master (
        output IN_start, IN_abort, IN_exact, IN_approx,
        input  OUT_vec, OUT_busy, OUT_done, OUT_aborted, OUT_err_cnt, OUT_any_cnt,
               OUT_first_fail, OUT_first_valid
    );
    modport slave (
        input  IN_start, IN_abort, IN_exact, IN_approx,
        output OUT_vec, OUT_busy, OUT_done, OUT_aborted, OUT_err_cnt, OUT_any_cnt,
               OUT_first_fail, OUT_first_valid
    );
endinterface

// File: rtl/approx_sweep_ctrl.sv
// approx_sweep_ctrl: exhaustive exact-vs-approximate sweep with mismatch statistics.
module approx_sweep_ctrl #(
    parameter int N_IN = 5,
    parameter int N_OUT = 2,
    parameter int SETTLE = 1,
    parameter int CNT_W = N_IN + 1
) (
    input logic CLK,
    input logic RST,
    approx_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, CMP, DONE} state_t;
    localparam logic [3:0] SL = 4'(SETTLE == 0 ? 0 : SETTLE - 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(1) << N_IN;

    state_t state_q, state_d;
    logic [3:0] cnt;
    logic [N_IN-1:0] vec, first_fail;
    logic [N_OUT*CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] any_cnt;
    logic aborted, first_valid, busy, stop;
    logic [N_OUT-1:0] mm;

    assign busy = state_q == HOLD || state_q == CMP;
    assign stop = busy && bus.IN_abort;
    assign mm = bus.IN_exact ^ bus.IN_approx;

    always_ff @(posedge CLK) state_q <= RST ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = bus.IN_start ? (SETTLE == 0 ? CMP : HOLD) : IDLE;
            HOLD: state_d = stop ? DONE : (cnt == SL ? CMP : HOLD);
            CMP: state_d = stop || &vec ? DONE : (SETTLE == 0 ? CMP : HOLD);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            vec <= '0;
            err_cnt <= '0;
            any_cnt <= '0;
            first_fail <= '0;
            first_valid <= 1'b0;
            aborted <= 1'b0;
        end else begin
            cnt <= (state_q == HOLD && state_d == HOLD) ? cnt + 4'd1 : 4'd0;
            if (state_q == IDLE && bus.IN_start) begin
                vec <= '0;
                err_cnt <= '0;
                any_cnt <= '0;
                first_fail <= '0;
                first_valid <= 1'b0;
                aborted <= 1'b0;
            end else if (stop) begin
                vec <= '0;
                aborted <= 1'b1;
            end else if (state_q == CMP) begin
                // the last vector wraps to 0, which is what IDLE/DONE must show
                vec <= vec + 1'b1;
                for (int i = 0; i < N_OUT; i++)
                    if (mm[i] && err_cnt[i*CNT_W +: CNT_W] != MAX)
                        err_cnt[i*CNT_W +: CNT_W] <= err_cnt[i*CNT_W +: CNT_W] + 1'b1;
                if (|mm) begin
                    if (any_cnt != MAX) any_cnt <= any_cnt + 1'b1;
                    if (!first_valid) begin
                        first_fail <= vec;
                        first_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.OUT_vec = vec;
    assign bus.OUT_busy = busy;
    assign bus.OUT_done = state_q == DONE;
    assign bus.OUT_aborted = aborted;
    assign bus.OUT_err_cnt = err_cnt;
    assign bus.OUT_any_cnt = any_cnt;
    assign bus.OUT_first_fail = first_fail;
    assign bus.OUT_first_valid = first_valid;
endmodule

// File: tb/tb_approx_sweep_ctrl.sv
// tb_approx_sweep_ctrl: two controllers (SETTLE=1 and SETTLE=0) checked every cycle against a timeline model.
module tb_approx_sweep_ctrl;
    localparam int NI = 5, NO = 2, CW = 6, NV = 32;

    logic clk, rst;
    logic [1:0] st, ab;
    logic [NO-1:0] ex_tbl[NV], er_tbl[NV];
    int n_vec, n_mis;
    bit go;

    approx_sweep_ctrl_if #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) ifc0 ();
    approx_sweep_ctrl_if #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) ifc1 ();

    approx_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .SETTLE(0), .CNT_W(CW)) dut0 (.CLK(clk), .RST(rst), .bus(ifc0));
    approx_sweep_ctrl #(.N_IN(NI), .N_OUT(NO), .SETTLE(1), .CNT_W(CW)) dut1 (.CLK(clk), .RST(rst), .bus(ifc1));

    // both DUT pairs are modelled as lookup tables addressed by the stimulus vector
    assign ifc0.IN_start = st[0];
    assign ifc0.IN_abort = ab[0];
    assign ifc0.IN_exact = ex_tbl[ifc0.OUT_vec];
    assign ifc0.IN_approx = ex_tbl[ifc0.OUT_vec] ^ er_tbl[ifc0.OUT_vec];
    assign ifc1.IN_start = st[1];
    assign ifc1.IN_abort = ab[1];
    assign ifc1.IN_exact = ex_tbl[ifc1.OUT_vec];
    assign ifc1.IN_approx = ex_tbl[ifc1.OUT_vec] ^ er_tbl[ifc1.OUT_vec];

    logic [1:0] busy_o, done_o, abd_o, fv_o;
    logic [NI-1:0] vec_o[2], ff_o[2];
    logic [NO*CW-1:0] err_o[2];
    logic [CW-1:0] any_o[2];
    assign busy_o = {ifc1.OUT_busy, ifc0.OUT_busy};
    assign done_o = {ifc1.OUT_done, ifc0.OUT_done};
    assign abd_o = {ifc1.OUT_aborted, ifc0.OUT_aborted};
    assign fv_o = {ifc1.OUT_first_valid, ifc0.OUT_first_valid};
    assign vec_o[0] = ifc0.OUT_vec;
    assign vec_o[1] = ifc1.OUT_vec;
    assign ff_o[0] = ifc0.OUT_first_fail;
    assign ff_o[1] = ifc1.OUT_first_fail;
    assign err_o[0] = ifc0.OUT_err_cnt;
    assign err_o[1] = ifc1.OUT_err_cnt;
    assign any_o[0] = ifc0.OUT_any_cnt;
    assign any_o[1] = ifc1.OUT_any_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: a sweep is a count k of busy cycles; vector k/(S+1) is compared when k%(S+1)==S
    bit m_act[2], m_done[2], m_ab[2], m_fv[2];
    int m_k[2], m_any[2], m_ff[2];
    int m_err[2][NO];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic step(input int i, input int s, input bit sv, input bit av);
        int v;
        logic [NO-1:0] e;
        if (rst) begin
            m_act[i] = 0; m_done[i] = 0; m_ab[i] = 0; m_fv[i] = 0;
            m_k[i] = 0; m_any[i] = 0; m_ff[i] = 0;
            for (int b = 0; b < NO; b++) m_err[i][b] = 0;
        end else if (m_act[i]) begin
            if (av) begin
                m_act[i] = 0; m_done[i] = 1; m_ab[i] = 1;
            end else begin
                if (m_k[i] % (s + 1) == s) begin
                    v = m_k[i] / (s + 1);
                    e = er_tbl[v];
                    for (int b = 0; b < NO; b++) if (e[b] && m_err[i][b] < NV) m_err[i][b]++;
                    if (e != 0) begin
                        if (m_any[i] < NV) m_any[i]++;
                        if (!m_fv[i]) begin m_ff[i] = v; m_fv[i] = 1; end
                    end
                    if (v == NV - 1) begin m_act[i] = 0; m_done[i] = 1; end
                end
                m_k[i]++;
            end
        end else if (m_done[i]) m_done[i] = 0;
        else if (sv) begin
            m_act[i] = 1; m_k[i] = 0; m_ab[i] = 0; m_fv[i] = 0; m_any[i] = 0; m_ff[i] = 0;
            for (int b = 0; b < NO; b++) m_err[i][b] = 0;
        end
    endtask

    always @(posedge clk) begin
        step(0, 0, st[0], ab[0]);
        step(1, 1, st[1], ab[1]);
        go = 1;
    end

    task automatic cmp(input int i, input int s);
        logic [NO*CW-1:0] ee;
        for (int b = 0; b < NO; b++) ee[b*CW +: CW] = CW'(m_err[i][b]);
        chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_act[i]));
        chk($sformatf("done%0d", i), 32'(done_o[i]), 32'(m_done[i]));
        chk($sformatf("aborted%0d", i), 32'(abd_o[i]), 32'(m_ab[i]));
        chk($sformatf("vec%0d", i), 32'(vec_o[i]), m_act[i] ? m_k[i] / (s + 1) : 0);
        chk($sformatf("err%0d", i), 32'(err_o[i]), 32'(ee));
        chk($sformatf("any%0d", i), 32'(any_o[i]), m_any[i]);
        chk($sformatf("fv%0d", i), 32'(fv_o[i]), 32'(m_fv[i]));
        if (m_fv[i]) chk($sformatf("ff%0d", i), 32'(ff_o[i]), m_ff[i]);
    endtask

    always @(negedge clk) if (go) begin
        cmp(0, 0);
        cmp(1, 1);
    end

    task automatic pulse(input int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    // waits for done from the cycle after start acceptance; optional restart/abort injection at cycle rs/aa
    task automatic wait_done(input int i, input int rs, input int aa, output int n, output int nb);
        n = 0;
        nb = 0;
        while (!done_o[i] && n < 400) begin
            if (busy_o[i]) nb++;
            n++;
            st[i] = (n == rs);
            ab[i] = (n == aa);
            @(negedge clk);
        end
        st[i] = 1'b0;
        ab[i] = 1'b0;
        chk($sformatf("done_seen%0d", i), 32'(done_o[i]), 1);
    endtask

    task automatic wait_vec(input int i, input int v);
        int n = 0;
        while (vec_o[i] != NI'(v) && n < 200) begin n++; @(negedge clk); end
        chk("vec_reached", 32'(vec_o[i]), v);
    endtask

    initial begin
        int n, nb, sel, aa;
        n_vec = 0; n_mis = 0; go = 0;
        rst = 1'b1; st = '0; ab = '0;
        for (int v = 0; v < NV; v++) begin ex_tbl[v] = NO'($urandom); er_tbl[v] = '0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy_o[1]), 0);
        chk("rst_any", 32'(any_o[1]), 0);
        ab[1] = 1'b1;
        @(negedge clk);
        ab[1] = 1'b0;

        // identical outputs: 64 busy cycles, nothing counted
        pulse(1);
        wait_done(1, -1, -1, n, nb);
        chk("s1_busy_cycles", nb, 64);
        chk("s1_any", 32'(any_o[1]), 0);
        chk("s1_err", 32'(err_o[1]), 0);
        chk("s1_fv", 32'(fv_o[1]), 0);

        // bit0 always inverted
        for (int v = 0; v < NV; v++) er_tbl[v] = 2'b01;
        pulse(1);
        wait_done(1, -1, -1, n, nb);
        chk("s2_err0", 32'(err_o[1][CW-1:0]), 32);
        chk("s2_err1", 32'(err_o[1][2*CW-1:CW]), 0);
        chk("s2_any", 32'(any_o[1]), 32);
        chk("s2_ff", 32'(ff_o[1]), 0);
        chk("s2_fv", 32'(fv_o[1]), 1);

        // bit1 differs only at 0x13 and 0x1E
        for (int v = 0; v < NV; v++) er_tbl[v] = '0;
        er_tbl[5'h13] = 2'b10;
        er_tbl[5'h1E] = 2'b10;
        pulse(1);
        wait_done(1, -1, -1, n, nb);
        chk("s3_err1", 32'(err_o[1][2*CW-1:CW]), 2);
        chk("s3_err0", 32'(err_o[1][CW-1:0]), 0);
        chk("s3_any", 32'(any_o[1]), 2);
        chk("s3_ff", 32'(ff_o[1]), 32'h13);
        repeat (2) @(negedge clk);
        chk("s3_stable", 32'(any_o[1]), 2);

        // SETTLE=0 with a repeated start mid-sweep
        for (int v = 0; v < NV; v++) er_tbl[v] = NO'($urandom);
        pulse(0);
        wait_done(0, 5, -1, n, nb);
        chk("s4_cycles", n, 32);
        chk("s4_busy_cycles", nb, 32);

        // abort during vector 10
        for (int v = 0; v < NV; v++) er_tbl[v] = 2'b01;
        pulse(1);
        wait_vec(1, 10);
        ab[1] = 1'b1;
        @(negedge clk);
        ab[1] = 1'b0;
        chk("s5_done", 32'(done_o[1]), 1);
        chk("s5_aborted", 32'(abd_o[1]), 1);
        chk("s5_any", 32'(any_o[1]), 10);
        chk("s5_err0", 32'(err_o[1][CW-1:0]), 10);
        @(negedge clk);
        st[1] = 1'b1;
        ab[1] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0;
        ab[1] = 1'b0;
        chk("s5_restart_aborted", 32'(abd_o[1]), 0);
        chk("s5_restart_busy", 32'(busy_o[1]), 1);
        wait_done(1, -1, -1, n, nb);
        chk("s5_full_any", 32'(any_o[1]), 32);

        // reset during vector 20
        pulse(1);
        wait_vec(1, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_busy", 32'(busy_o[1]), 0);
        chk("s6_done", 32'(done_o[1]), 0);
        chk("s6_vec", 32'(vec_o[1]), 0);
        chk("s6_any", 32'(any_o[1]), 0);
        chk("s6_err", 32'(err_o[1]), 0);
        chk("s6_fv", 32'(fv_o[1]), 0);
        repeat (3) @(negedge clk);
        pulse(1);
        wait_done(1, -1, -1, n, nb);
        chk("s6_clean_any", 32'(any_o[1]), 32);

        // randomized sweeps on either controller, some aborted
        for (int r = 0; r < 8; r++) begin
            sel = $urandom_range(0, 1);
            for (int v = 0; v < NV; v++) er_tbl[v] = ($urandom_range(0, 3) == 0) ? NO'($urandom) : '0;
            aa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 50) : -1;
            pulse(sel);
            wait_done(sel, $urandom_range(1, 20), aa, n, nb);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/approx_sweep_ctrl.md
Name: approx_sweep_ctrl

Overview:
- Sequencer that exhaustively sweeps every input vector through an exact combinational netlist and its approximate counterpart (e.g. 5-input/2-output c17 pair), both driven from the same stimulus bus.
- Samples both output buses after a programmable settle time, compares them and accumulates error statistics: per-output mismatch counts, any-mismatch count, first failing vector.
- Sits between the approximate-circuit DUT pair and the reliability-evaluation host, which starts a sweep and reads results when done pulses.

Parameters:
- N_IN, 5, stimulus width; sweep covers 2^N_IN vectors, legal range 1..16.
- N_OUT, 2, width of each DUT output bus, legal range 1..8.
- SETTLE, 1, idle cycles each vector is held before sampling, legal range 0..15.
- CNT_W, N_IN+1, counter width; must hold the value 2^N_IN.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous active-high reset.
- IN_start  input  1  one-cycle request to begin a sweep.
- IN_abort  input  1  terminate the running sweep.
- IN_exact  input  N_OUT  exact DUT outputs.
- IN_approx  input  N_OUT  approximate DUT outputs.
- OUT_vec  output  N_IN  stimulus to both DUTs.
- OUT_busy  output  1  high while a sweep is in progress.
- OUT_done  output  1  one-cycle pulse when a sweep completes or aborts.
- OUT_aborted  output  1  high if the last sweep ended by abort; held until next start.
- OUT_err_cnt  output  N_OUT*CNT_W  per-bit mismatch counts; bit i's count in slice [i*CNT_W +: CNT_W].
- OUT_any_cnt  output  CNT_W  number of vectors with at least one mismatching bit.
- OUT_first_fail  output  N_IN  first vector with any mismatch; valid only when OUT_first_valid is high.
- OUT_first_valid  output  1  a failing vector has been captured in this sweep.

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- Reset values: all outputs 0; FSM in IDLE; internal settle counter 0.
- FSM states:
  - IDLE:
    - IN_start=1 -> HOLD.
    - Same edge clears all counters, OUT_first_valid, OUT_aborted.
    - Same edge sets the vector to 0.
  - HOLD:
    - Settle counter runs 0..SETTLE-1.
    - At count SETTLE-1 -> CMP.
    - With SETTLE=0, HOLD is skipped and IDLE goes directly to CMP.
  - CMP (one cycle):
    - Compares IN_exact against IN_approx. This cycle's input values are the ones counted.
    - Each mismatching bit i increments count i.
    - If any bit mismatches, OUT_any_cnt increments.
    - If any bit mismatches and OUT_first_valid=0, the current vector is captured and OUT_first_valid is set.
    - Vector = 2^N_IN-1 -> DONE; otherwise the vector increments and the FSM goes to HOLD (or stays in CMP when SETTLE=0).
  - DONE (one cycle): OUT_done=1, OUT_busy=0, then IDLE.
- OUT_busy:
  - High in HOLD and CMP only.
  - Registered: rises the cycle after start is accepted, falls the cycle OUT_done pulses.
- OUT_vec:
  - Registered; stable for exactly SETTLE+1 cycles per vector.
  - Reads 0 in IDLE and DONE.
- Sweep length: 2^N_IN*(SETTLE+1) busy cycles. OUT_done is on the cycle after the last CMP.
- Counters saturate at their maximum (2^N_IN); no wrap.
- IN_start while busy, or in DONE: ignored.
- IN_abort:
  - Only acted on in HOLD or CMP.
  - Next state DONE; OUT_aborted set.
  - Counters keep their partial values. A CMP in the abort cycle is NOT counted.
- IN_abort in IDLE: ignored. Simultaneous IN_start+IN_abort in IDLE: start is accepted, abort is ignored.
- RST mid-sweep: all state and results return to reset values; no OUT_done pulse.
- Results stay stable from OUT_done until the next accepted start.

Test Plan:
- IN_approx tied to IN_exact, SETTLE=1 -> after 64 busy cycles OUT_done pulses; all counts 0; OUT_first_valid=0; OUT_vec walks 0..31, each value held for 2 cycles.
- IN_approx = IN_exact with bit0 inverted -> err count bit0=32, bit1=0, OUT_any_cnt=32, OUT_first_fail=0, OUT_first_valid=1.
- Approx differs only on bit1 at vectors 0x13 and 0x1E -> err count bit1=2, OUT_any_cnt=2, OUT_first_fail=0x13.
- SETTLE=0, start asserted again while busy -> done pulses exactly 32 cycles after the first start is accepted; the second start has no effect.
- IN_abort asserted during vector 10 -> OUT_done pulses next cycle; OUT_aborted=1; counts reflect vectors 0..9 only; the next start clears OUT_aborted.
- RST asserted during vector 20 -> next cycle all outputs 0, FSM idle, no done pulse; a new start runs a full clean sweep.
